mem_port_arbiter: RTL

//  Shares one single-port synchronous memory between the fetch stage (IF) and the load/store stage (DM).

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_lat_timer.sv | 32 +++
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, FSM encodings and owner codes for the IF/DM memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned AddrWidth  = 32;
  localparam int unsigned InstrWidth = 32;

  localparam logic [1:0] ArbIdle  = 2'd0;
  localparam logic [1:0] ArbIssue = 2'd1;
  localparam logic [1:0] ArbWait  = 2'd2;
  localparam logic [1:0] ArbDone  = 2'd3;

  localparam logic OwnIf = 1'b0;
  localparam logic OwnDm = 1'b1;

  function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] max);
    return (val >= max) ? max : val + 4'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_timer.sv
// Loadable 4-bit down-counter that flags the last wait cycle of a memory access.
module mem_port_arbiter_lat_timer (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       done_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 4'd1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store,
// one transaction at a time, with a fixed memory latency and a streak limit favouring fetch.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned ADDR_W     = AddrWidth,
  parameter int unsigned DATA_W     = InstrWidth
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  input  logic [3:0]        dm_be_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_stall_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [3:0] LatLoad   = 4'(MEM_LAT - 1);
  localparam logic [3:0] MaxStreak = 4'(MAX_STREAK);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              mem_en_q, mem_en_d;
  logic [3:0]        streak_q, streak_d;
  logic              cancel_q, cancel_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic tmr_load, tmr_dec, tmr_done;
  logic if_elig, dm_elig, grant_if, grant_dm;

  mem_port_arbiter_lat_timer u_lat_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (tmr_load),
    .load_val_i (LatLoad),
    .dec_i      (tmr_dec),
    .done_o     (tmr_done)
  );

  // A requester being acked this cycle is masked so it is not granted twice.
  assign if_elig  = if_req_i & ~if_ack_q & ~if_flush_i;
  assign dm_elig  = dm_req_i & ~dm_ack_q;
  assign grant_if = if_elig & (~dm_elig | (streak_q == MaxStreak));
  assign grant_dm = dm_elig & ~grant_if;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    streak_d   = streak_q;
    cancel_d   = cancel_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;

    unique case (state_q)
      ArbIdle: begin
        cancel_d = 1'b0;
        if (grant_dm) begin
          owner_d  = OwnDm;
          addr_d   = dm_addr_i;
          we_d     = dm_we_i;
          wdata_d  = dm_wdata_i;
          be_d     = dm_be_i;
          streak_d = if_req_i ? sat_inc(streak_q, MaxStreak) : 4'd0;
          state_d  = ArbIssue;
        end else if (grant_if) begin
          owner_d  = OwnIf;
          addr_d   = if_addr_i;
          we_d     = 1'b0;
          wdata_d  = '0;
          be_d     = '0;
          streak_d = 4'd0;
          state_d  = ArbIssue;
        end
      end
      ArbIssue: begin
        tmr_load = 1'b1;
        state_d  = (MEM_LAT == 1) ? ArbDone : ArbWait;
      end
      ArbWait: begin
        tmr_dec = 1'b1;
        if (tmr_done) begin
          state_d = ArbDone;
        end
      end
      ArbDone: begin
        state_d = ArbIdle;
        if (owner_q == OwnDm) begin
          dm_ack_d = 1'b1;
          if (!we_q) begin
            dm_rdata_d = mem_rdata_i;
          end
        end else if (!cancel_q && !if_flush_i) begin
          if_ack_d   = 1'b1;
          if_rdata_d = mem_rdata_i;
        end
      end
      default: state_d = ArbIdle;
    endcase

    // A redirect while fetch owns the port lets the access finish but drops its result.
    if ((state_q != ArbIdle) && (owner_q == OwnIf) && if_flush_i) begin
      cancel_d = 1'b1;
    end
  end

  assign mem_en_d = (state_d == ArbIssue);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ArbIdle;
      owner_q    <= OwnIf;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      mem_en_q   <= 1'b0;
      streak_q   <= '0;
      cancel_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      mem_en_q   <= mem_en_d;
      streak_q   <= streak_d;
      cancel_q   <= cancel_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign if_ack_o    = if_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_stall_o  = if_req_i & ~if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_stall_o  = dm_req_i & ~dm_ack_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;

endmodule
